scroll_text_engine: RTL and testbench
=====================================

# scroll_text_engine

Consumes the 1 Hz square wave from the slow-clock divider and scrolls a MSG_LEN-character message across the 8-digit seven-segment display. Each rising edge of the step input advances a circular window offset, left or right. The block time-multiplexes the eight common-anode digits itself and drives the board's anode, segment and decimal-point pins directly. It sits between the slow-clock divider (upstream) and the display pins (downstream).

## Interface
- MSG_LEN, 16: message length in characters; legal range 8..32.
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz).
- OW, $clog2(MSG_LEN): offset width (derived; not overridden).
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  reset; one clock, synchronous, active-low.
- step_in  in  1  1 Hz square wave from the divider, same clk domain; each rising edge is one scroll step.
- pause  in  1  1 = ignore steps and freeze the offset.
- dir  in  1  0 = scroll left (offset+1); 1 = scroll right (offset-1).
- msg  in  MSG_LEN*5  message; char i = msg[5i+4:5i], char 0 is first; must be held static.
- an  out  8  digit anodes, active-low; an[7] is the leftmost digit.
- seg  out  7  segments, active-low, seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low; tied to 1 (off).
- offset  out  OW  current window start index, for debug and verification.

## Operation
- Edge detect: step_q registers step_in. step_rise = step_in & ~step_q. No synchronizer is needed because the input is in the same clock domain.
- Offset update, on step_rise with pause=0:
  - dir=0: offset = (offset==MSG_LEN-1) ? 0 : offset+1.
  - dir=1: offset = (offset==0) ? MSG_LEN-1 : offset-1.
- Pause: step_rise with pause=1 is discarded, not queued. Releasing pause does not cause a catch-up step.
- Window: digit k (k=0 rightmost, an[0]) shows char index (offset + 7 - k) mod MSG_LEN. The leftmost digit therefore shows msg char at offset. Mod is computed as a compare-and-subtract on an OW+1-bit sum.
- Refresh: ref_cnt counts 0..REFRESH_DIV-1 and wraps.
  - At the terminal count, digit index dig (3 bits) increments, wrapping 7→0.
- Character decode, 5-bit codes:
  - 0-9: digits.
  - 10 A, 11 b, 12 C, 13 d, 14 E, 15 F, 16 H, 17 L, 18 n, 19 o, 20 P, 21 r, 22 U, 23 '-'.
  - 24-31: blank.
- Reference segment values:
  - '0' = 7'b1000000.
  - '1' = 7'b1111001.
  - 'H' = 7'b0001001.
  - 'E' = 7'b0000110.
  - 'L' = 7'b1000111.
  - '-' = 7'b0111111.
  - blank = 7'b1111111.
- Internal states: a single scan loop, with dig cycling through S0..S7. There is no other FSM. The scroll path is independent of the scan path.

## Timing
- Reset (rst_n=0 at a clk edge), next cycle:
  - offset=0, step_q=0, ref_cnt=0, dig=0.
  - an=8'hFF, seg=7'h7F, dp=1.
- Reset asserted mid-operation overrides everything, including a coincident step_rise.
- an and seg are registered.
  - They reflect dig and offset with 1-cycle latency.
  - The first cycle after reset release gives an=8'b11111110.
  - an and seg always change on the same edge, so there is no ghosting cycle.
- Offset latency:
  - offset changes on the edge after the cycle in which step_in first samples 1.
  - seg for the currently scanned digit reflects the new offset one cycle after that.
- A step coincident with a refresh wrap: both take effect. seg is decoded with the new dig and the old offset on that edge, then corrected on the next edge.
- dir and pause are sampled only in a step_rise cycle.
- Steps at most one per 2 clk cycles; a step_in held high produces exactly one step.

## Test plan
Benches use REFRESH_DIV=4 and MSG_LEN=16 unless noted.

- Reset: hold rst_n=0 for 3 cycles, then release -> an=FF, seg=7F, offset=0 during reset; an=FE on cycle 1 after release.
- Scan: msg chars 0..7 = codes 0..7, offset=0 -> an steps FE,FD,…,7F every 4 cycles; an=7F shows '0' (seg=40); an=FE shows code 7.
- Scroll left with wrap: 16 rising edges on step_in, dir=0 -> offset 1,2,…,15,0; each change lands 1 cycle after the edge.
- Scroll right with wrap: from offset=0, one edge with dir=1 -> offset=15; leftmost digit shows char 15; rightmost digit shows char 6.
- Pause: edges with pause=1 -> offset unchanged; pause released while step_in stays high -> no step; next real edge -> exactly +1.
- Reset mid-scroll: assert rst_n=0 in the same cycle as a step_rise at offset=9 -> offset=0, an=FF; the step is lost.

Source files
------------

// File: rtl/scroll_text_engine.sv
// Scrolls a MSG_LEN-character message across an 8-digit common-anode seven-segment display.
// The scroll offset follows rising edges of step_in; the digit scan runs freely off ref_cnt.
module scroll_text_engine #(
  parameter int MSG_LEN     = 16,
  parameter int REFRESH_DIV = 100000,
  parameter int OW          = $clog2(MSG_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step_in,
  input  logic                 pause,
  input  logic                 dir,
  input  logic [MSG_LEN*5-1:0] msg,
  output logic [7:0]           an,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [OW-1:0]        offset
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} dig_t;

  logic          step_q;
  logic          step_rise;
  logic [OW-1:0] offset_q, offset_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  dig_t          dig_q, dig_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    rev;
  logic [OW:0]   sum;
  logic [OW:0]   idx;
  logic [4:0]    ch;

  function automatic logic [6:0] font(input logic [4:0] c);
    logic [6:0] s;
    case (c)
      5'd0:    s = 7'b1000000;
      5'd1:    s = 7'b1111001;
      5'd2:    s = 7'b0100100;
      5'd3:    s = 7'b0110000;
      5'd4:    s = 7'b0011001;
      5'd5:    s = 7'b0010010;
      5'd6:    s = 7'b0000010;
      5'd7:    s = 7'b1111000;
      5'd8:    s = 7'b0000000;
      5'd9:    s = 7'b0010000;
      5'd10:   s = 7'b0001000;
      5'd11:   s = 7'b0000011;
      5'd12:   s = 7'b1000110;
      5'd13:   s = 7'b0100001;
      5'd14:   s = 7'b0000110;
      5'd15:   s = 7'b0001110;
      5'd16:   s = 7'b0001001;
      5'd17:   s = 7'b1000111;
      5'd18:   s = 7'b0101011;
      5'd19:   s = 7'b0100011;
      5'd20:   s = 7'b0001100;
      5'd21:   s = 7'b0101111;
      5'd22:   s = 7'b1000001;
      5'd23:   s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    step_rise = step_in & ~step_q;

    offset_d = offset_q;
    if (step_rise && !pause) begin
      if (!dir)
        offset_d = (offset_q == OW'(MSG_LEN-1)) ? '0 : offset_q + 1'b1;
      else
        offset_d = (offset_q == '0) ? OW'(MSG_LEN-1) : offset_q - 1'b1;
    end

    if (ref_cnt_q == RW'(REFRESH_DIV-1)) begin
      ref_cnt_d = '0;
      dig_d     = dig_t'(dig_q + 3'd1);
    end else begin
      ref_cnt_d = ref_cnt_q + 1'b1;
      dig_d     = dig_q;
    end

    // Outputs are decoded from the next digit so an and seg move together;
    // the window uses the registered offset, so a fresh step shows up one edge later.
    rev  = 3'd7 - dig_d;
    sum  = {1'b0, offset_q} + {{(OW-2){1'b0}}, rev};
    idx  = (sum >= (OW+1)'(MSG_LEN)) ? sum - (OW+1)'(MSG_LEN) : sum;
    ch   = msg[5*idx +: 5];
    an_d = ~(8'd1 << dig_d);
    seg_d = font(ch);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q    <= 1'b0;
      offset_q  <= '0;
      ref_cnt_q <= '0;
      dig_q     <= S0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
    end else begin
      step_q    <= step_in;
      offset_q  <= offset_d;
      ref_cnt_q <= ref_cnt_d;
      dig_q     <= dig_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an     = an_q;
  assign seg    = seg_q;
  assign dp     = 1'b1;
  assign offset = offset_q;

endmodule

// File: tb/tb_scroll_text_engine.sv
// Directed bench for scroll_text_engine with REFRESH_DIV=4, MSG_LEN=16.
// Inputs change and outputs are sampled on the falling edge.
module tb_scroll_text_engine;

  localparam int MSG_LEN     = 16;
  localparam int REFRESH_DIV = 4;
  localparam int OW          = $clog2(MSG_LEN);

  logic                 clk;
  logic                 rst_n;
  logic                 step_in;
  logic                 pause;
  logic                 dir;
  logic [MSG_LEN*5-1:0] msg;
  logic [7:0]           an;
  logic [6:0]           seg;
  logic                 dp;
  logic [OW-1:0]        offset;

  int n_cmp = 0;
  int n_bad = 0;

  scroll_text_engine #(.MSG_LEN(MSG_LEN), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_in (step_in),
    .pause   (pause),
    .dir     (dir),
    .msg     (msg),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .offset  (offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
  } scan_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits (bounded) until digit k is being driven, then checks its segments.
  task automatic check_digit(input int k, input logic [6:0] exp, input string name);
    logic [7:0] want;
    bit found;
    want  = ~(8'd1 << k);
    found = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if (an === want) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: digit %0d never scanned, an=%0h", name, k, an);
    end else begin
      check(name, {25'd0, seg}, {25'd0, exp});
    end
  endtask

  initial begin
    int codes[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 16, 14, 17, 23, 24, 10, 21, 22};
    scan_vec_t scan_tbl[8];

    // Offset 0: digit k shows char 7-k.
    scan_tbl[0] = '{8'hFE, 7'h78};
    scan_tbl[1] = '{8'hFD, 7'h02};
    scan_tbl[2] = '{8'hFB, 7'h12};
    scan_tbl[3] = '{8'hF7, 7'h19};
    scan_tbl[4] = '{8'hEF, 7'h30};
    scan_tbl[5] = '{8'hDF, 7'h24};
    scan_tbl[6] = '{8'hBF, 7'h79};
    scan_tbl[7] = '{8'h7F, 7'h40};

    for (int i = 0; i < 16; i++) msg[5*i +: 5] = 5'(codes[i]);
    rst_n   = 1'b0;
    step_in = 1'b0;
    pause   = 1'b0;
    dir     = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_an", {24'd0, an}, 32'hFF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_offset", {28'd0, offset}, 32'd0);
    check("dp_off", {31'd0, dp}, 32'd1);

    rst_n = 1'b1;
    for (int v = 0; v < 8; v++) begin
      if (v == 0) @(negedge clk);
      else repeat (REFRESH_DIV) @(negedge clk);
      check($sformatf("scan_an%0d", v), {24'd0, an}, {24'd0, scan_tbl[v].an});
      check($sformatf("scan_seg%0d", v), {25'd0, seg}, {25'd0, scan_tbl[v].seg});
    end

    // Scroll left through a full wrap.
    dir = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step_in = 1'b1;
      @(negedge clk);
      check($sformatf("left_off%0d", i), {28'd0, offset}, 32'((i + 1) % 16));
      step_in = 1'b0;
      @(negedge clk);
      if (i == 7) begin
        check_digit(7, 7'b0001001, "win8_left_H");
        check_digit(0, 7'b1000001, "win8_right_U");
      end
    end

    // Scroll right wraps 0 -> 15.
    dir     = 1'b1;
    step_in = 1'b1;
    @(negedge clk);
    check("right_off15", {28'd0, offset}, 32'd15);
    step_in = 1'b0;
    check_digit(7, 7'b1000001, "win15_left_U");
    check_digit(0, 7'b0000010, "win15_right_6");

    // Pause discards steps; releasing it with step_in high is not a step.
    @(negedge clk);
    pause   = 1'b1;
    step_in = 1'b1;
    @(negedge clk);
    check("pause_edge1", {28'd0, offset}, 32'd15);
    step_in = 1'b0;
    @(negedge clk);
    step_in = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    repeat (3) @(negedge clk);
    check("pause_release", {28'd0, offset}, 32'd15);
    step_in = 1'b0;
    dir     = 1'b0;
    @(negedge clk);
    step_in = 1'b1;
    repeat (4) @(negedge clk);
    check("after_pause_once", {28'd0, offset}, 32'd0);
    step_in = 1'b0;
    @(negedge clk);

    // Reset coincident with a step at offset 9.
    for (int i = 0; i < 9; i++) begin
      step_in = 1'b1;
      @(negedge clk);
      step_in = 1'b0;
      @(negedge clk);
    end
    check("pre_rst_off9", {28'd0, offset}, 32'd9);
    step_in = 1'b1;
    rst_n   = 1'b0;
    @(negedge clk);
    check("midrst_offset", {28'd0, offset}, 32'd0);
    check("midrst_an", {24'd0, an}, 32'hFF);
    check("midrst_seg", {25'd0, seg}, 32'h7F);
    rst_n   = 1'b1;
    step_in = 1'b0;
    @(negedge clk);
    check("midrst_release_an", {24'd0, an}, 32'hFE);
    repeat (3) @(negedge clk);
    check("midrst_step_lost", {28'd0, offset}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
